// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the decode-side operand stage.
//   DW, AW          : datapath and register-address widths
//   RS/RT/RD_HI/LO  : instruction field bit positions
//   IMM_HI/LO       : immediate field bit positions
//   R0              : hardwired-zero register number
package id_operand_stage_pkg;
  localparam int DW = 32;
  localparam int AW = 5;

  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [AW-1:0] R0 = '0;
endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Operand forwarding select for one source register.
//   src                             : source register number
//   ex_wn/ex_wreg/ex_m2reg/ex_alu   : EX-stage producer tuple
//   mm_wn/mm_wreg/mm_m2reg/mm_alu/mm_mo : MEM-stage producer tuple
//   wb_wn/wb_we/wb_d                : WB write port (same edge as regfile)
//   rf_d                            : register file read data
//   q                               : selected operand
// Priority: r0 -> 0, EX (non-load), MEM, WB, regfile.
module fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int W  = DW,
  parameter int AWD = AW
) (
  input  logic [AWD-1:0] src,
  input  logic [AWD-1:0] ex_wn,
  input  logic           ex_wreg,
  input  logic           ex_m2reg,
  input  logic [W-1:0]   ex_alu,
  input  logic [AWD-1:0] mm_wn,
  input  logic           mm_wreg,
  input  logic           mm_m2reg,
  input  logic [W-1:0]   mm_alu,
  input  logic [W-1:0]   mm_mo,
  input  logic [AWD-1:0] wb_wn,
  input  logic           wb_we,
  input  logic [W-1:0]   wb_d,
  input  logic [W-1:0]   rf_d,
  output logic [W-1:0]   q
);
  always_comb begin
    q = rf_d;
    if (src == AWD'(0))
      q = '0;
    // A load in EX has no data yet; the hazard unit stalls if it matters.
    else if (ex_wreg && ex_wn == src && !ex_m2reg)
      q = ex_alu;
    else if (mm_wreg && mm_wn == src)
      q = mm_m2reg ? mm_mo : mm_alu;
    // Regfile writes at the posedge, so the same-cycle WB value is bypassed.
    else if (wb_we && wb_wn == src)
      q = wb_d;
  end
endmodule

// File: rtl/id_operand_stage.sv
// Decode operand stage: regfile addressing, operand forwarding, load-use
// stall generation and the ID/EX pipeline register.
//   clk, clrn           : clock, async active-low reset
//   d_*                 : instruction and decode control from IF/ID
//   flush               : redirect, kills the instruction in ID
//   rna/rnb, qa/qb      : register file read ports
//   ex_*, mm_*, wb_*    : downstream producers for forwarding
//   stall               : hold PC and IF/ID (combinational)
//   e_*                 : ID/EX register outputs
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DW = id_operand_stage_pkg::DW,
  parameter int AW = id_operand_stage_pkg::AW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [31:0]   d_inst,
  input  logic          d_valid,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic          d_regrt,
  input  logic          d_wreg,
  input  logic          d_m2reg,
  input  logic          flush,
  output logic [AW-1:0] rna,
  output logic [AW-1:0] rnb,
  input  logic [DW-1:0] qa,
  input  logic [DW-1:0] qb,
  input  logic [AW-1:0] ex_wn,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [DW-1:0] ex_alu,
  input  logic [AW-1:0] mm_wn,
  input  logic          mm_wreg,
  input  logic          mm_m2reg,
  input  logic [DW-1:0] mm_alu,
  input  logic [DW-1:0] mm_mo,
  input  logic [AW-1:0] wb_wn,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_d,
  output logic          stall,
  output logic [DW-1:0] e_a,
  output logic [DW-1:0] e_b,
  output logic [DW-1:0] e_imm,
  output logic [AW-1:0] e_wn,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_valid
);
  logic [AW-1:0] rs, rt, rd, dst;
  logic [15:0]   imm;
  logic [DW-1:0] fa, fb, sext;
  logic          hazard, bubble;

  // Opcode bits are decoded upstream.
  logic unused_opc;
  assign unused_opc = &{1'b0, d_inst[31:26]};

  assign rs  = d_inst[RS_HI:RS_LO];
  assign rt  = d_inst[RT_HI:RT_LO];
  assign rd  = d_inst[RD_HI:RD_LO];
  assign imm = d_inst[IMM_HI:IMM_LO];
  assign rna = rs;
  assign rnb = rt;

  assign sext = {{(DW-16){imm[15]}}, imm};
  assign dst  = d_regrt ? rt : rd;

  fwd_mux #(.W(DW), .AWD(AW)) u_fwd_a (
    .src(rs),
    .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_alu(ex_alu),
    .mm_wn(mm_wn), .mm_wreg(mm_wreg), .mm_m2reg(mm_m2reg),
    .mm_alu(mm_alu), .mm_mo(mm_mo),
    .wb_wn(wb_wn), .wb_we(wb_we), .wb_d(wb_d),
    .rf_d(qa), .q(fa)
  );

  fwd_mux #(.W(DW), .AWD(AW)) u_fwd_b (
    .src(rt),
    .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_alu(ex_alu),
    .mm_wn(mm_wn), .mm_wreg(mm_wreg), .mm_m2reg(mm_m2reg),
    .mm_alu(mm_alu), .mm_mo(mm_mo),
    .wb_wn(wb_wn), .wb_we(wb_we), .wb_d(wb_d),
    .rf_d(qb), .q(fb)
  );

  // One-cycle stall: next cycle the load is in MEM and mm_mo forwards.
  assign hazard = d_valid & ex_wreg & ex_m2reg & (ex_wn != AW'(0)) &
                  ((d_use_rs & (ex_wn == rs)) | (d_use_rt & (ex_wn == rt)));
  assign stall  = hazard & ~flush;
  assign bubble = flush | hazard | ~d_valid;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_valid <= 1'b0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_imm   <= '0;
      e_wn    <= '0;
    end else if (bubble) begin
      e_valid <= 1'b0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_imm   <= '0;
      e_wn    <= '0;
    end else begin
      e_valid <= 1'b1;
      e_wreg  <= d_wreg & (dst != AW'(0));
      e_m2reg <= d_m2reg;
      e_a     <= fa;
      e_b     <= fb;
      e_imm   <= sext;
      e_wn    <= dst;
    end
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: per-scenario tasks push the
// expected ID/EX contents to a scoreboard queue and pop/compare after the edge.
module tb_id_operand_stage;
  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] d_inst;
  logic        d_valid, d_use_rs, d_use_rt, d_regrt, d_wreg, d_m2reg, flush;
  logic [4:0]  rna, rnb;
  logic [31:0] qa, qb;
  logic [4:0]  ex_wn, mm_wn, wb_wn;
  logic        ex_wreg, ex_m2reg, mm_wreg, mm_m2reg, wb_we;
  logic [31:0] ex_alu, mm_alu, mm_mo, wb_d;
  logic        stall;
  logic [31:0] e_a, e_b, e_imm;
  logic [4:0]  e_wn;
  logic        e_wreg, e_m2reg, e_valid;

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic        m2reg;
    logic [4:0]  wn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  exp_t got, e;
  int   errors = 0;
  int   checks = 0;

  assign got = {e_valid, e_wreg, e_m2reg, e_wn, e_a, e_b, e_imm};

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .clrn(clrn), .d_inst(d_inst), .d_valid(d_valid),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_regrt(d_regrt),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .flush(flush),
    .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_alu(ex_alu),
    .mm_wn(mm_wn), .mm_wreg(mm_wreg), .mm_m2reg(mm_m2reg),
    .mm_alu(mm_alu), .mm_mo(mm_mo),
    .wb_wn(wb_wn), .wb_we(wb_we), .wb_d(wb_d),
    .stall(stall), .e_a(e_a), .e_b(e_b), .e_imm(e_imm), .e_wn(e_wn),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_valid(e_valid)
  );

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  task automatic set_idle();
    d_inst = '0; d_valid = 0; d_use_rs = 0; d_use_rt = 0; d_regrt = 0;
    d_wreg = 0; d_m2reg = 0; flush = 0; qa = '0; qb = '0;
    ex_wn = '0; ex_wreg = 0; ex_m2reg = 0; ex_alu = '0;
    mm_wn = '0; mm_wreg = 0; mm_m2reg = 0; mm_alu = '0; mm_mo = '0;
    wb_wn = '0; wb_we = 0; wb_d = '0;
  endtask

  task automatic test_reset();
    clrn = 0; set_idle(); #2;
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_init: got %h exp 0", got); end
    // valid instruction while held in reset must not load
    d_inst = mk(5'd1, 5'd2, 16'h1805); d_valid = 1; d_use_rs = 1; d_use_rt = 1;
    d_wreg = 1; qa = 32'h100; qb = 32'h200;
    @(posedge clk); #1;
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_hold: got %h exp 0", got); end
    checks++;
    if (rna !== 5'd1 || rnb !== 5'd2) begin
      errors++; $display("FAIL rf_addr: got %h/%h exp 01/02", rna, rnb);
    end
    clrn = 1;
    sb.push_back('{1'b1, 1'b1, 1'b0, 5'd3, 32'h100, 32'h200, 32'h1805});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_first: got %h exp %h", got, e); end
    // async reset mid-cycle; stall still follows its inputs
    #2; ex_wn = 5'd2; ex_wreg = 1; ex_m2reg = 1; clrn = 0; #1;
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_async: got %h exp 0", got); end
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b exp 1", stall); end
    #1; clrn = 1; set_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_ex_fwd();
    set_idle();
    d_inst = mk(5'd3, 5'd4, 16'h4820); d_valid = 1; d_use_rs = 1; d_use_rt = 1;
    d_wreg = 1; qa = 32'hDEAD; qb = 32'h1234;
    ex_wn = 5'd3; ex_wreg = 1; ex_alu = 32'h10;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ex_fwd_stall: got %b exp 0", stall); end
    sb.push_back('{1'b1, 1'b1, 1'b0, 5'd9, 32'h10, 32'h1234, 32'h4820});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL ex_fwd: got %h exp %h", got, e); end
  endtask

  task automatic test_priority();
    set_idle();
    d_inst = mk(5'd5, 5'd6, 16'hFFF0); d_valid = 1; d_use_rs = 1; d_regrt = 1;
    d_wreg = 1; qa = 32'hAAAA; qb = 32'hBBBB;
    ex_wn = 5'd5; ex_wreg = 1; ex_alu = 32'h1;
    mm_wn = 5'd5; mm_wreg = 1; mm_alu = 32'h2; mm_mo = 32'h77;
    wb_wn = 5'd5; wb_we = 1; wb_d = 32'h3;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea;
      case (i)
        0: ea = 32'h1;
        1: begin ex_wreg = 0; ea = 32'h2; end
        2: begin mm_wreg = 0; ea = 32'h3; end
        default: begin wb_we = 0; ea = 32'hAAAA; end
      endcase
      sb.push_back('{1'b1, 1'b1, 1'b0, 5'd6, ea, 32'hBBBB, 32'hFFFF_FFF0});
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL priority_%0d: got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_load_use();
    set_idle();
    d_inst = mk(5'd1, 5'd7, 16'h4000); d_valid = 1; d_use_rs = 1; d_use_rt = 1;
    d_wreg = 1; qa = 32'h11; qb = 32'h22;
    ex_wn = 5'd7; ex_wreg = 1; ex_m2reg = 1; ex_alu = 32'h1000;
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", stall); end
    sb.push_back('0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lu_bubble: got %h exp %h", got, e); end
    // load advanced to MEM; EX now holds the bubble
    ex_wn = '0; ex_wreg = 0; ex_m2reg = 0; ex_alu = '0;
    mm_wn = 5'd7; mm_wreg = 1; mm_m2reg = 1; mm_alu = 32'h1000; mm_mo = 32'hCAFE;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b exp 0", stall); end
    sb.push_back('{1'b1, 1'b1, 1'b0, 5'd8, 32'h11, 32'hCAFE, 32'h4000});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lu_fwd: got %h exp %h", got, e); end
    // load in EX matching rt, but rt not read: no stall; also a load in ID
    set_idle();
    d_inst = mk(5'd1, 5'd7, 16'h0004); d_valid = 1; d_use_rs = 1; d_regrt = 1;
    d_wreg = 1; d_m2reg = 1; qa = 32'h40;
    ex_wn = 5'd7; ex_wreg = 1; ex_m2reg = 1;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_nouse: got %b exp 0", stall); end
    sb.push_back('{1'b1, 1'b1, 1'b1, 5'd7, 32'h40, 32'h0, 32'h4});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL lu_ldinst: got %h exp %h", got, e); end
  endtask

  task automatic test_r0();
    set_idle();
    d_inst = mk(5'd0, 5'd2, 16'h0001); d_valid = 1; d_use_rs = 1; d_use_rt = 1;
    d_wreg = 1; qa = 32'h5555; qb = 32'h66;
    ex_wn = 5'd0; ex_wreg = 1; ex_m2reg = 1; ex_alu = 32'hFFFF;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b exp 0", stall); end
    ex_m2reg = 0;
    sb.push_back('{1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h66, 32'h1});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL r0_fwd: got %h exp %h", got, e); end
  endtask

  task automatic test_flush();
    set_idle();
    d_inst = mk(5'd9, 5'd10, 16'h0008); d_valid = 1; d_use_rs = 1; d_wreg = 1;
    qa = 32'h99; ex_wn = 5'd9; ex_wreg = 1; ex_m2reg = 1; flush = 1;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b exp 0", stall); end
    sb.push_back('0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL flush_bubble: got %h exp %h", got, e); end
    // invalid slot with hazard pattern: no stall, bubble
    flush = 0; d_valid = 0;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL inval_stall: got %b exp 0", stall); end
    sb.push_back('0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL inval_bubble: got %h exp %h", got, e); end
  endtask

  task automatic test_back_to_back();
    set_idle();
    for (int i = 0; i < 8; i++) begin
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic        rg;
      rs = 5'($urandom_range(1, 31)); rt = 5'($urandom_range(1, 31));
      rd = 5'($urandom_range(1, 31)); rg = 1'($urandom_range(0, 1));
      imm = {rd, 11'($urandom)};
      d_inst = mk(rs, rt, imm); d_valid = 1; d_use_rs = 1; d_use_rt = 1;
      d_regrt = rg; d_wreg = 1; qa = $urandom; qb = $urandom;
      sb.push_back('{1'b1, 1'b1, 1'b0, (rg ? rt : rd), qa, qb, {{16{imm[15]}}, imm}});
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL b2b_%0d: got %h exp %h", i, got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_priority();
    test_load_use();
    test_r0();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side operand stage of the 5-stage pipeline.
- Drives the register file read addresses and selects each operand from the register file or a forwarding path (EX, MEM, WB).
- Detects load-use hazards and generates the IF/ID stall.
- Captures operands and destination control into the ID/EX pipeline register, inserting bubbles on stall or flush.

Parameters:
- DW, 32, datapath width
- AW, 5, register address width (32 architectural registers, r0 hardwired zero)

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous reset, active-low
- d_inst  in  32  instruction from IF/ID register
- d_valid  in  1  IF/ID holds a real instruction
- d_use_rs  in  1  instruction reads rs (inst[25:21])
- d_use_rt  in  1  instruction reads rt (inst[20:16])
- d_regrt  in  1  destination is rt; else rd (inst[15:11])
- d_wreg  in  1  instruction writes a register
- d_m2reg  in  1  instruction is a load
- flush  in  1  branch/jump redirect; kill the instruction in ID
- rna  out  AW  register file read address A = inst[25:21]
- rnb  out  AW  register file read address B = inst[20:16]
- qa  in  DW  register file read data A
- qb  in  DW  register file read data B
- ex_wn  in  AW  EX-stage destination
- ex_wreg  in  1  EX-stage writes
- ex_m2reg  in  1  EX-stage is a load
- ex_alu  in  DW  EX-stage ALU result
- mm_wn  in  AW  MEM-stage destination
- mm_wreg  in  1  MEM-stage writes
- mm_m2reg  in  1  MEM-stage is a load
- mm_alu  in  DW  MEM-stage ALU result
- mm_mo  in  DW  MEM-stage load data
- wb_wn  in  AW  WB destination (same signal as register file wn)
- wb_we  in  1  WB write enable
- wb_d  in  DW  WB write data
- stall  out  1  hold PC and IF/ID (combinational)
- e_a  out  DW  registered operand A
- e_b  out  DW  registered operand B
- e_imm  out  DW  registered sign-extended inst[15:0]
- e_wn  out  AW  registered destination
- e_wreg  out  1  registered write enable
- e_m2reg  out  1  registered load flag
- e_valid  out  1  ID/EX holds a real instruction

Behaviour:
- rna and rnb are driven combinationally from d_inst fields every cycle, regardless of use flags.
- Per-operand forward select, highest priority first; a source register of 0 never forwards and yields 0:
  - EX: ex_wreg, ex_wn==src, not ex_m2reg -> ex_alu
  - MEM: mm_wreg, mm_wn==src -> mm_mo if mm_m2reg, else mm_alu
  - WB: wb_we, wb_wn==src -> wb_d. This covers the register file's same-edge write; the register file only updates at the posedge.
  - Otherwise -> qa/qb.
- Load-use hazard: d_valid & ex_wreg & ex_m2reg & ex_wn!=0 & ((d_use_rs & ex_wn==rs) | (d_use_rt & ex_wn==rt)).
- stall = hazard & ~flush. Stall lasts exactly one cycle, because the load then sits in MEM and forwards mm_mo.
- Destination: e_wn source = d_regrt ? rt : rd. When the destination is 0, e_wreg is forced to 0.
- ID/EX register, updated at posedge clk:
  - On flush, or stall, or ~d_valid: load a bubble. e_valid, e_wreg and e_m2reg = 0. e_a, e_b, e_imm and e_wn = 0.
  - Otherwise load the forwarded operands, sign-extended immediate and control.
- Flush and hazard in the same cycle: flush wins; bubble, stall = 0.
- Reset (clrn low, asynchronous, any time including mid-stall): all e_* outputs = 0. stall follows its inputs combinationally.
- Single-cycle latency from ID inputs to e_* outputs. No internal state beyond the ID/EX register.

Decomposition:
- Shared package: DW, AW, instruction field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO), R0 constant.
- One natural sub-module, fwd_mux, instantiated twice (operand A, operand B).
  - Inputs: src, the three stage tuples, register file data.
  - Outputs: the selected value.

Test Plan:
- Reset: clrn=0 mid-run -> all e_* = 0 immediately. After release, first valid instruction appears one cycle later.
- EX forward: EX writes r3=0x0000_0010 (non-load); ID reads rs=r3, regfile qa=0xDEAD -> e_a=0x10 next edge, stall=0.
- Priority: EX r5=0x1, MEM r5=0x2, WB r5=0x3 all active -> e_a=0x1. Remove EX -> 0x2. Remove MEM -> 0x3.
- Load-use: EX is a load to r7, ID uses rt=r7 -> stall=1 one cycle and bubble (e_valid=0). Next cycle mm_mo=0xCAFE forwards -> e_b=0xCAFE, stall=0.
- r0: ID reads rs=r0 while EX "writes" r0=0xFFFF -> e_a=0. Instruction with rd=0 and d_wreg=1 -> e_wreg=0.
- Flush during hazard: flush=1 with load-use condition -> stall=0 and bubble loaded.
